// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter for the valid/ready memory bus.
// Master 0 is the CPU and master 1 is a secondary master. Each grant is held
// for exactly one complete transfer. There is always at least one IDLE cycle
// between grants.
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to compile in the watchdog.
// The watchdog ends a transfer that the slave never acknowledges. It returns
// ready with rdata=0 and pulses bus_error.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic        m0_instr,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_instr,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_instr,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t state, state_nxt;
    logic   last_grant, last_grant_nxt;
    logic   active;
    logic   sel_m1;
    logic   sel_valid;
    logic   expire;

    // Reset gates the outputs so the bus is quiet while reset_n is low.
    assign active    = (state != IDLE) && reset_n;
    assign sel_m1    = (state == GRANT1);
    assign sel_valid = sel_m1 ? m1_valid : m0_valid;

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // A withdrawn request or a late s_ready takes priority over expiry.
    assign expire = active && sel_valid && !s_ready && (wd_cnt == 16'(TIMEOUT_CYCLES));

    // Watchdog counter: cleared in IDLE (so every grant starts at 0), counts
    // grant cycles without s_ready, and saturates.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (state == IDLE) begin
            wd_cnt <= '0;
        end else if (!s_ready && (wd_cnt != 16'hFFFF)) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // State and round-robin pointer registers.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next-state logic: arbitration in IDLE, and termination out of a grant.
    // NOTE: defaults are assigned first so no path leaves a variable unassigned (no latch).
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (m0_valid && (!m1_valid || last_grant)) begin
                    state_nxt      = GRANT0;
                    last_grant_nxt = 1'b0;
                end else if (m1_valid) begin
                    state_nxt      = GRANT1;
                    last_grant_nxt = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (s_ready || !sel_valid || expire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output mux: route the owner's request downstream and the response back.
    always_comb begin
        s_valid   = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_instr   = 1'b0;
        grant     = 2'b00;
        m0_ready  = 1'b0;
        m0_rdata  = '0;
        m1_ready  = 1'b0;
        m1_rdata  = '0;
        bus_error = expire;
        if (active) begin
            s_valid = sel_valid && !expire;
            if (sel_m1) begin
                grant    = 2'b10;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                s_instr  = m1_instr;
                m1_ready = (sel_valid && s_ready) || expire;
                m1_rdata = expire ? 32'h0 : s_rdata;
            end else begin
                grant    = 2'b01;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                s_instr  = m0_instr;
                m0_ready = (sel_valid && s_ready) || expire;
                m0_rdata = expire ? 32'h0 : s_rdata;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter for the SoC's valid/ready memory bus. Master 0 is the picorv32 CPU; master 1 is a secondary bus master such as a loader or debug engine. The block sits between both masters and the address-decode/mux logic. It grants the single downstream port round-robin and holds each grant for one complete transfer. An optional watchdog terminates transfers that the decoded slave never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, number of grant cycles without s_ready before forced termination. Legal range 1..65535; used only when the watchdog is compiled in.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- m0_valid / m1_valid  in  1  master request, held until that master's ready
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_wstrb / m1_wstrb  in  4  byte write strobes; 0 = read
- m0_instr / m1_instr  in  1  instruction-fetch flag
- m0_ready / m1_ready  out  1  transfer-complete strobe to that master
- m0_rdata / m1_rdata  out  32  read data, valid when ready=1
- s_valid  out  1  downstream request
- s_addr  out  32  downstream address
- s_wdata  out  32  downstream write data
- s_wstrb  out  4  downstream write strobes
- s_instr  out  1  downstream instruction-fetch flag
- s_ready  in  1  downstream completion
- s_rdata  in  32  downstream read data
- grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1
- bus_error  out  1  one-cycle pulse on a watchdog termination

## Operation
- State register with three states: IDLE, GRANT0, GRANT1. last_grant is 1 bit.
- IDLE transitions:
  - Only m0_valid asserted -> GRANT0.
  - Only m1_valid asserted -> GRANT1.
  - Both asserted -> grant the master not equal to last_grant.
  - Neither asserted -> stay in IDLE.
  - On entering a grant state: last_grant takes the granted index and the watchdog counter clears.
- GRANTn behaviour:
  - s_valid = mn_valid; s_addr/s_wdata/s_wstrb/s_instr = master n's fields.
  - mn_ready = s_ready; mn_rdata = s_rdata (combinational pass-through).
  - The other master sees ready=0, rdata=0.
- GRANTn -> IDLE on any of:
  - s_ready=1 (normal completion).
  - mn_valid=0 (abandoned request): no ready is issued and the slave sees s_valid drop.
  - Watchdog expiry.
- IDLE outputs: s_valid=0, s_addr/s_wdata=0, s_wstrb=0, s_instr=0, grant=0, both ready=0, both rdata=0.
- No transfer is ever split, reordered or pre-empted.

## Timing
- Reset state: IDLE, last_grant=1 so that m0 wins the first contention, counter=0. Every output is 0 during and immediately after reset.
- Reset asserted mid-grant: next cycle is IDLE and all outputs are 0; the in-flight transfer is dropped without a ready.
- Arbitration latency: a request seen in IDLE in cycle N produces grant and s_valid in cycle N+1.
- Completion: mn_ready is asserted in the same cycle as s_ready. The next cycle is always IDLE.
- Minimum spacing: 2 cycles between consecutive grants, so the fastest transfer is 2 cycles per access. A master that re-asserts valid directly after its ready loses to a waiting opposite master.
- Watchdog counter: 16 bits. It increments in each grant cycle where s_ready=0, and saturates.
- Expiry: the watchdog fires in the grant cycle where counter == TIMEOUT_CYCLES and s_ready=0. That cycle has:
  - mn_ready=1 and mn_rdata=32'h0 (illegal instruction, so a CPU fetch traps);
  - s_valid=0;
  - bus_error=1.
- If s_ready=1 arrives in the expiry cycle, it wins: normal completion, no bus_error.

## Configuration
- MEM_ARBITER_TIMEOUT_EN defined: the watchdog counter, the forced termination and bus_error are present as described above.
- Not defined: there is no counter and a grant waits indefinitely for s_ready or valid withdrawal. bus_error is tied to 0 and TIMEOUT_CYCLES is ignored.

## Test plan
- Single m0 read at addr 32'h0000_0010; slave returns s_rdata=32'h1234_5678 with s_ready in the 3rd grant cycle -> grant=01 one cycle after m0_valid; m0_ready and m0_rdata=32'h1234_5678 in that same cycle; IDLE next cycle.
- m0_valid and m1_valid both asserted immediately after reset, each slave access taking 1 cycle -> order is m0, then m1, then m0. Each grant is separated by one IDLE cycle.
- m1 write with m1_wstrb=4'hF and m1_wdata=32'hCAFE_F00D -> s_wstrb=4'hF and s_wdata=32'hCAFE_F00D while grant=10; m0_ready stays 0 throughout.
- Watchdog, macro defined, TIMEOUT_CYCLES=4, s_ready held low -> m0_ready=1, m0_rdata=0 and bus_error=1 in the 5th grant cycle, s_valid=0 in that cycle. Repeat with s_ready=1 in exactly that cycle -> slave data is returned and bus_error=0.
- reset_n pulsed low in the 2nd cycle of a GRANT1 transfer -> all outputs are 0 the next cycle. A subsequent m0/m1 contention is granted to m0 first.
- Macro undefined, s_ready held low for 1000 cycles -> grant holds, m0_ready=0 and bus_error=0 for all 1000 cycles.
